imem_ctrl: RTL

Instruction-memory responder for the fetch path: it accepts the fetch address the IFU drives every cycle and returns the addressed 32-bit instruction with a valid strobe one clock later. It owns a single-port synchronous word array, a loader write port for program images, and a small boot state machine that gates fetches until a program is loaded. It sits between the IFU (fetch requests), the EXU (hold/flush) and the boot loader.

---
 rtl/imem_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory for the fetch path: one-cycle fetch, loader write port, boot FSM.
// Optional IMEM_INIT_CLEAR_EN adds a CLEAR state that fills the array with NOPs after reset.
module imem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              fetch_err_o,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              ld_ready_o,
  input  logic              ld_done_i,
  output logic              run_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IMEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
  localparam state_t S_RST = S_CLEAR;
`else
  typedef enum logic [1:0] {S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
  localparam state_t S_RST = S_LOAD;
`endif

  state_t            r_state;
  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_rdata;
  logic [31:0]       r_instr_q;
  logic              r_use_rd;
  logic              r_valid;
  logic              r_err;

  logic              w_run;
  logic              w_ld_wr;
  logic              w_pc_err;
  logic              w_re;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_instr;

  assign w_run    = (r_state == S_RUN);
  assign w_ld_wr  = ld_we_i && ((r_state == S_LOAD) || w_run);
  assign w_pc_err = (pc_i[1:0] != 2'b00) || (pc_i[31:ADDR_W+2] != '0);
  // a loader write owns the single port, so it suppresses the fetch
  assign w_re     = w_run && !flush_i && !hold_i && !ld_we_i && !w_pc_err;

`ifdef IMEM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] r_cnt;
  logic              w_clr;
  assign w_clr   = (r_state == S_CLEAR);
  assign w_we    = w_ld_wr || w_clr;
  assign w_waddr = w_clr ? r_cnt : ld_addr_i;
  assign w_wdata = w_clr ? NOP   : ld_wdata_i;
`else
  assign w_we    = w_ld_wr;
  assign w_waddr = ld_addr_i;
  assign w_wdata = ld_wdata_i;
`endif

  // array and read register carry no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_re) r_rdata <= r_mem[pc_i[ADDR_W+1:2]];
  end

  // r_use_rd selects fresh RAM data; otherwise the captured copy is replayed
  assign w_instr = r_use_rd ? r_rdata : r_instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RST;
      r_use_rd  <= 1'b0;
      r_instr_q <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef IMEM_INIT_CLEAR_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_use_rd <= w_re;
      if (!w_re) r_instr_q <= w_instr;
      r_err <= 1'b0;
      case (r_state)
`ifdef IMEM_INIT_CLEAR_EN
        S_CLEAR: begin
          r_valid <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == '1) r_state <= S_LOAD;
        end
`endif
        S_LOAD: begin
          r_valid <= 1'b0;
          if (ld_done_i) r_state <= S_RUN;
        end
        S_RUN: begin
          if (flush_i)        r_valid <= 1'b0;
          else if (hold_i)    r_valid <= r_valid;
          else if (ld_we_i)   r_valid <= 1'b0;
          else if (w_pc_err) begin
            r_valid   <= 1'b0;
            r_err     <= 1'b1;
            r_instr_q <= '0;
          end else            r_valid <= 1'b1;
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  assign instr_o       = w_instr;
  assign instr_valid_o = r_valid;
  assign fetch_err_o   = r_err;
  assign run_o         = w_run;
`ifdef IMEM_INIT_CLEAR_EN
  assign ld_ready_o    = (r_state != S_CLEAR);
`else
  assign ld_ready_o    = 1'b1;
`endif

endmodule
